// File: rtl/phase_ctrl.sv
// phase_ctrl: instruction-phase sequencer for the multi-cycle core.
// Drives a one-hot F/R/X/M/W phase vector (f=bit0 .. w=bit4), handles
// free-run and single-step execution, memory wait-state stretching with a
// timeout fault, halt on HLT, and keeps a retired-instruction counter.
module phase_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             clear,
  input  logic [3:0]       op,
  input  logic             mem_wait,
  output logic [4:0]       phase,
  output logic             ir_load,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // Controller states
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  // One-hot phase encodings
  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_F    = 5'b00001;
  localparam logic [4:0] PH_R    = 5'b00010;
  localparam logic [4:0] PH_X    = 5'b00100;
  localparam logic [4:0] PH_M    = 5'b01000;
  localparam logic [4:0] PH_W    = 5'b10000;

  localparam logic [3:0] OP_HLT = 4'b1111;

  // Wait counter wide enough to hold WAIT_MAX
  localparam int unsigned WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  // Value the counter holds on the stalled cycle that exhausts the budget
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  logic [1:0]        r_state;
  logic [4:0]        r_phase;
  logic [WCNT_W-1:0] r_wait;
  logic              r_halted;
  logic              r_fault;
  logic [CNT_W-1:0]  r_retired;

  logic [1:0]        w_state_nxt;
  logic [4:0]        w_phase_nxt;
  logic [WCNT_W-1:0] w_wait_nxt;
  logic              w_retire;
  logic              w_w_exit;
  logic              w_stall_timeout;

  assign w_stall_timeout = mem_wait && (r_wait == WAIT_LAST);
  assign w_w_exit        = (r_state == S_RUN) && (r_phase == PH_W);

  // Next-state, next-phase and wait-counter decode
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_wait_nxt  = r_wait;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = PH_NONE;
        if (start) begin
          w_state_nxt = S_RUN;
          w_phase_nxt = PH_F;
        end
      end
      S_RUN: begin
        case (r_phase)
          PH_F: w_phase_nxt = PH_R;
          PH_R: w_phase_nxt = PH_X;
          PH_X: begin
            w_phase_nxt = PH_M;
            w_wait_nxt  = '0;
          end
          PH_M: begin
            if (!mem_wait) begin
              w_phase_nxt = PH_W;
              w_wait_nxt  = '0;
            end else if (w_stall_timeout) begin
              w_state_nxt = S_FAULT;
              w_phase_nxt = PH_NONE;
              w_wait_nxt  = '0;
            end else begin
              w_wait_nxt = r_wait + 1'b1;
            end
          end
          PH_W: begin
            // Every W exit retires, HLT included; op is only looked at here
            w_retire = 1'b1;
            if (op == OP_HLT) begin
              w_state_nxt = S_HALTED;
              w_phase_nxt = PH_NONE;
            end else if (step_mode) begin
              w_state_nxt = S_IDLE;
              w_phase_nxt = PH_NONE;
            end else begin
              w_phase_nxt = PH_F;
            end
          end
          default: begin
            // Corrupted phase register: drop back to IDLE rather than wedge
            w_state_nxt = S_IDLE;
            w_phase_nxt = PH_NONE;
            w_wait_nxt  = '0;
          end
        endcase
      end
      S_HALTED, S_FAULT: begin
        w_phase_nxt = PH_NONE;
        // clear has priority; start is never honoured from these states
        if (clear) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = PH_NONE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Controller state, phase vector and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= PH_NONE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Registered status flags follow the next state so they align with phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_halted <= (w_state_nxt == S_HALTED);
      r_fault  <= (w_state_nxt == S_FAULT);
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W, survives HALTED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign phase   = r_phase;
  assign ir_load = r_phase[0];
  assign busy    = |r_phase;
  assign halted  = r_halted;
  assign fault   = r_fault;
  assign retired = r_retired;

  // Phase vector is one-hot whenever busy, and busy exactly in RUN
  a_phase_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> $onehot(r_phase));
  a_busy_run : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (r_state == S_RUN));
  a_retire_at_w : assert property (@(posedge clk) disable iff (!rst_n)
    w_retire |-> w_w_exit);

endmodule

// File: doc/phase_ctrl.md
Name: phase_ctrl

Overview:
- Instruction-phase sequencer for the multi-cycle core.
- Generates the one-hot phase vector consumed by the decoder, register file, ALU and memory stages: f=bit0, r=bit1, x=bit2, m=bit3, w=bit4.
- Supports free-run and single-step modes, memory wait-state stalls, halt on HLT, and halt/restart control.
- Keeps a retired-instruction counter for the debug bus.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- WAIT_MAX, 15, max consecutive mem_wait cycles tolerated in m before timeout fault

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin execution from IDLE
- step_mode  in  1  1 = stop in IDLE after each instruction's w phase
- clear  in  1  pulse: leave HALTED/FAULT, return to IDLE
- op  in  4  decoded opcode from decoder (HLT = 4'b1111)
- mem_wait  in  1  memory not ready; stretch m phase
- phase  out  5  one-hot phase vector, all-zero when not running
- ir_load  out  1  fetch strobe, equals phase[0]
- busy  out  1  1 while phase is non-zero
- halted  out  1  1 in HALTED state
- fault  out  1  1 in FAULT state (mem_wait timeout)
- retired  out  CNT_W  count of completed w phases

Behaviour:
- States: IDLE, RUN, HALTED, FAULT. In RUN, phase is one of F,R,X,M,W; outside RUN, phase = 5'b0.
- Reset (async, rst_n=0): state=IDLE, phase=0, halted=0, fault=0, retired=0, wait counter=0. Reset mid-instruction aborts with no retire.
- IDLE: start=1 -> RUN with phase=F on the next edge. Otherwise stay.
- RUN advances one phase per clock: F->R->X->M->W.
  - F->R->X unconditional.
  - M: mem_wait=1 holds M and increments the wait counter.
  - mem_wait=0 -> W, wait counter cleared.
  - Wait counter reaching WAIT_MAX while mem_wait still 1 -> FAULT, phase=0, no retire.
- W exit, priority order:
  1. op==HLT -> HALTED.
  2. else step_mode=1 -> IDLE.
  3. else F.
  - In all three cases retired increments by 1 on the W edge; HLT counts as retired.
  - retired wraps modulo 2^CNT_W.
- op is sampled only in W. The decoder latches it at the end of F, so it is stable from R onward.
- HALTED: halted=1. start ignored. clear=1 -> IDLE, halted=0. retired is held, not cleared.
- FAULT: fault=1. start ignored. clear=1 -> IDLE, fault=0.
- start while RUN: ignored. clear while RUN or IDLE: ignored. start and clear in the same cycle in HALTED/FAULT: clear wins, start dropped.
- step_mode change mid-instruction takes effect at the next W exit only.
- Outputs:
  - phase, halted, fault and retired are registered.
  - ir_load and busy are combinational decodes of the phase register.
  - Exactly one phase bit is set whenever busy=1 (must hold as an assertion).
- Latency: start -> phase F = 1 cycle. Unstalled instruction = 5 cycles. Back-to-back free-run throughput = 1 instruction per 5 cycles. Each mem_wait cycle adds 1.

Test Plan:
- Reset, start pulse, step_mode=0, op=ADD, mem_wait=0 for 20 cycles -> phase sequence 01,02,04,08,10 repeating; retired=4 at cycle 21; ir_load high only in F cycles.
- mem_wait=1 for 3 cycles on entry to M -> M held 4 cycles total, then W; retired increments once; no fault.
- op=HLT presented during an instruction -> after W: phase=0, halted=1, retired incremented. A start pulse then has no effect. clear -> IDLE; a following start resumes with F.
- step_mode=1, start -> exactly 5 busy cycles, then IDLE with retired=1. Second start -> retired=2.
- mem_wait held high with WAIT_MAX=15 -> FAULT after 15 stalled cycles, phase=0, fault=1, retired unchanged. clear -> fault=0, IDLE.
- rst_n pulled low asynchronously mid-X (between edges) -> phase=0, retired=0 immediately, without waiting for an edge. After release, start behaves as from cold reset.
